serial_pattern_tx: RTL and testbench

Serial pattern transmitter: accepts a parallel WIDTH-bit word through a start/ready handshake and drives it out MSB-first, one bit per clock, on a single-bit serial line with a qualifying valid strobe.
- Supports programmable frame repetition with a fixed inter-frame gap.
- It is the stimulus-side counterpart of the serial sequence detectors in this design and feeds their `in` input directly.
- All outputs are registered.

---
 rtl/serial_pattern_tx.sv | 153 +++++++++++++++
 tb/tb_serial_pattern_tx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: parallel-to-serial pattern transmitter.
// A word accepted on start/ready is shifted out MSB-first on out, qualified
// by out_valid, repeated (repeats + 1) times with GAP idle cycles between
// frames; done pulses in the cycle after the final bit.
// Optional feature: define SERIAL_PATTERN_TX_PARITY_EN to append an
// even-parity bit after each frame.
// The repeat-count input is named repeats because repeat is a keyword.
// Handshake: start is taken at a rising edge only while ready=1; data and
// repeats are sampled on that same edge and ignored at all other times.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int RPT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [RPT_W-1:0] repeats,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2, S_PAR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2} state_t;
`endif

  state_t             state, state_n;
  logic [WIDTH-1:0]   shreg, shreg_n;
  logic [WIDTH-1:0]   word, word_n;
  logic [RPT_W-1:0]   rpt_cnt, rpt_n;
  logic [BW-1:0]      bit_cnt, bit_n;
  logic [GW-1:0]      gap_cnt, gap_n;
  logic               frame_end;
  logic               out_n, valid_n, ready_n, done_n;

  // Next-state, datapath and output decode; outputs are computed from the
  // next state so that the registered outputs line up with the state.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    word_n    = word;
    rpt_n     = rpt_cnt;
    bit_n     = bit_cnt;
    gap_n     = gap_cnt;
    frame_end = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          shreg_n = data;
          word_n  = data;
          rpt_n   = repeats;
          bit_n   = '0;
          gap_n   = '0;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_cnt == BIT_LAST) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          state_n = S_PAR;
`else
          frame_end = 1'b1;
`endif
        end else begin
          shreg_n = shreg << 1;
          bit_n   = bit_cnt + 1'b1;
        end
      end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      S_PAR: begin
        frame_end = 1'b1;
      end
`endif
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_n   = '0;
          state_n = S_SHIFT;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Repeated frames restart from the latched word, not the shifted copy.
    if (frame_end) begin
      if (rpt_cnt != '0) begin
        rpt_n   = rpt_cnt - 1'b1;
        shreg_n = word;
        bit_n   = '0;
        gap_n   = '0;
        if (GAP > 0) state_n = S_GAP;
        else         state_n = S_SHIFT;
      end else begin
        state_n = S_IDLE;
      end
    end

    out_n   = 1'b0;
    valid_n = 1'b0;
    if (state_n == S_SHIFT) begin
      out_n   = shreg_n[WIDTH-1];
      valid_n = 1'b1;
    end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    if (state_n == S_PAR) begin
      out_n   = ^word_n;
      valid_n = 1'b1;
    end
`endif
    ready_n = (state_n == S_IDLE);
    done_n  = frame_end && (rpt_cnt == '0);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      word      <= '0;
      rpt_cnt   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      word      <= word_n;
      rpt_cnt   <= rpt_n;
      bit_cnt   <= bit_n;
      gap_cnt   <= gap_n;
      out       <= out_n;
      out_valid <= valid_n;
      ready     <= ready_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: scoreboard bench for serial_pattern_tx.
// The driver pushes the full expected per-cycle trace {ready,out_valid,out,done}
// for every accepted start plus the expected busy length; the monitor pops one
// entry each cycle (an empty queue means the block must be idle).
module tb_serial_pattern_tx;
  localparam int WIDTH = 8;
  localparam int GAP   = 2;
  localparam int RPT_W = 4;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam int B_ONE = 9;
  localparam int B_C3  = 31;
  localparam int B_R1  = 20;
  localparam int B_MAX = 174;
`else
  localparam int B_ONE = 8;
  localparam int B_C3  = 28;
  localparam int B_R1  = 18;
  localparam int B_MAX = 158;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] data;
  logic [RPT_W-1:0] repeats;
  logic             ready, out, out_valid, done;

  logic [3:0] exp_q[$];
  int         busy_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  int         busy_cnt = 0;
  logic [3:0] obs, expv;

  // Clock and reset
  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(WIDTH), .GAP(GAP), .RPT_W(RPT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .data(data), .repeats(repeats),
    .ready(ready), .out(out), .out_valid(out_valid), .done(done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare the observed outputs against the scoreboard every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      obs = {ready, out_valid, out, done};
      if (exp_q.size() > 0) expv = exp_q.pop_front();
      else                  expv = 4'b1000;
      check("trace_rdy_vld_out_done", {28'd0, obs}, {28'd0, expv});
      if (!ready) busy_cnt++;
      if (done) begin
        if (busy_q.size() > 0) begin
          check("busy_len", busy_cnt, busy_q.pop_front());
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got done=1 expected no done at %0t", $time);
        end
        busy_cnt = 0;
      end
    end
  end

  // Expected trace for one accepted start.
  task automatic push_trace(input logic [WIDTH-1:0] d, input logic [RPT_W-1:0] r);
    for (int f = 0; f <= int'(r); f++) begin
      for (int b = WIDTH - 1; b >= 0; b--) exp_q.push_back({1'b0, 1'b1, d[b], 1'b0});
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      exp_q.push_back({1'b0, 1'b1, ^d, 1'b0});
`endif
      if (f < int'(r)) for (int g = 0; g < GAP; g++) exp_q.push_back(4'b0000);
    end
    exp_q.push_back(4'b1001);
  endtask

  // Driver: wait for ready, present start for one accepted edge.
  // With hold set, start stays high and data/repeats are scrambled while busy.
  task automatic send(input logic [WIDTH-1:0] d, input logic [RPT_W-1:0] r,
                      input int exp_busy, input bit hold);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 2000) begin
      if (hold) begin
        data    = WIDTH'($urandom_range(0, 255));
        repeats = RPT_W'($urandom_range(0, 15));
      end
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got ready=0 expected ready=1");
      return;
    end
    start   = 1'b1;
    data    = d;
    repeats = r;
    @(posedge clk);
    push_trace(d, r);
    busy_q.push_back(exp_busy);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Stimulus sequence
  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    data    = '0;
    repeats = '0;
    @(posedge clk);
    mon_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    send(8'hA5, 4'd0, B_ONE, 1'b0);
    wait_idle();
    send(8'hC3, 4'd2, B_C3, 1'b0);
    wait_idle();

    send(8'h0F, 4'd0, B_ONE, 1'b1);
    send(8'h0F, 4'd0, B_ONE, 1'b1);
    send(8'h0F, 4'd1, B_R1, 1'b1);
    start = 1'b0;
    wait_idle();

    send(8'hFF, 4'd0, B_ONE, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    busy_q.delete();
    busy_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send(8'hFF, 4'd0, B_ONE, 1'b0);
    wait_idle();

    send(8'h07, 4'd0, B_ONE, 1'b0);
    wait_idle();
    send(8'h5A, 4'd15, B_MAX, 1'b0);
    wait_idle();

    repeat (3) @(negedge clk);
    check("busy_q_drained", busy_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
